mips_inst_encoder: RTL
======================

Name: mips_inst_encoder

Overview:
Streaming MIPS instruction encoder, the inverse of the control-unit decoder. Accepts symbolic instructions (mnemonic code plus fields) over a valid/ready handshake and packs each into a 32-bit machine word. Writes each word sequentially into instruction memory through a back-pressured write port. Used by the test/boot path to load programs into the single-cycle CPU's instruction memory.

Parameters:
WCW, 16, width of the written-word counter.
ADDR_INC, 4, byte increment of the write address per word.

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: begin a program load at base_addr (honoured in IDLE only)
base_addr  in  32  byte address of the first word
in_valid  in  1  instruction presented
in_ready  out  1  encoder accepts this cycle
in_mnem  in  5  mnemonic code (see package enum)
in_rs  in  5  rs field
in_rt  in  5  rt field
in_rd  in  5  rd field
in_shamt  in  5  shift amount
in_imm  in  16  immediate / branch operand
in_target  in  26  jump target field
in_last  in  1  marks the final instruction of the program
imem_we  out  1  write request; holds until imem_ready
imem_addr  out  32  write byte address
imem_wdata  out  32  encoded word
imem_ready  in  1  memory accepts the write this cycle
done  out  1  one-cycle pulse when the load is complete
err_illegal  out  1  sticky: an illegal mnemonic was received since the last start
word_count  out  WCW  words written since the last start

Behaviour:
- Reset (async, resetn=0): state=IDLE; in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, done=0, err_illegal=0, word_count=0, enc_ptr=0. Reset mid-load abandons the load and drops any buffered word.
- States:
  - IDLE: start -> RUN; enc_ptr<=base_addr, imem_addr<=base_addr, word_count<=0, err_illegal<=0.
  - RUN: start is ignored.
  - DRAIN: entered when in_last is accepted; waits until the output buffer is empty.
  - DONE: done=1 for exactly one cycle, then -> IDLE.
- Output buffer holds one entry; the imem_we flag is its valid bit.
- in_ready = (state==RUN) & (~imem_we | imem_ready). Full throughput: one word per cycle when imem_ready=1.
- Latency: a word accepted in cycle N appears on imem_* in cycle N+1.
- Write completes on imem_we & imem_ready. Then imem_addr += ADDR_INC and word_count += 1. If a new word is accepted in the same cycle, it loads into the buffer with the incremented address.
- While imem_we=1 and imem_ready=0: imem_addr and imem_wdata are held stable.
- enc_ptr += ADDR_INC on each legal acceptance. Address wraps modulo 2^32; word_count wraps modulo 2^WCW.
- Illegal mnemonic (codes 20..31): accepted (handshake completes) but nothing is written, enc_ptr unchanged, err_illegal<=1. in_last on an illegal entry is still honoured.
- Encoding (register field widths exact, no truncation needed):
  - R-type: {6'h00, rs, rt, rd, shamt, funct}.
  - sll/srl/sra: rs field forced to 0.
  - jr: rt, rd, shamt forced to 0.
  - Other R-type: shamt forced to 0.
  - I-type: {op, rs, rt, imm}; lui forces rs=0.
  - J-type (j, jal): {op, in_target}.
- Opcodes: addi 08, andi 0C, ori 0D, xori 0E, lui 0F, lw 23, sw 2B, beq 04, bne 05, j 02, jal 03.
- Functs: add 20, sub 22, and 24, or 25, xor 26, sll 00, srl 02, sra 03, jr 08.

Optional Feature:
MIPS_ENC_BRREL_EN:
- Defined: for beq/bne, in_imm is the absolute target word index (low 16 bits). Encoded imm = in_imm - (enc_ptr[17:2] + 1), modulo 2^16.
- Undefined: in_imm is copied verbatim for all I-types.

Decomposition:
- Package mips_isa_pkg holds:
  - mnemonic enum (add=0, sub, and, or, xor, sll, srl, sra, jr, addi, andi, ori, xori, lw, sw, beq, bne, lui, j, jal=19);
  - opcode and funct localparams;
  - state enum.
- Sub-module mips_enc_word: purely combinational mnemonic+fields(+enc_ptr) -> {word, illegal}. The top keeps the FSM, buffer and counters.

Test Plan:
- start base=0, add rs=1 rt=2 rd=3 shamt=7 last=1, imem_ready=1 -> next cycle imem_we=1, addr 0x0, wdata 0x00221820; done pulses after the write; word_count=1.
- start base=0x100, lw rt=5 rs=29 imm=8 then j target=0x0100000 (last) -> writes 0x8FA50008@0x100, 0x08100000@0x104.
- imem_ready low 3 cycles during a stream of 4 words -> in_ready=0 while stalled; addr/wdata stable; all 4 words written in order, none lost or duplicated.
- in_mnem=25 between two legal ops -> err_illegal=1 until next start; legal words at consecutive addresses; word_count=2.
- MIPS_ENC_BRREL_EN defined, base 0, two nops (sll 0) then beq rs=1 rt=2 in_imm=0 -> wdata 0x1022FFFD@0x8. Undefined -> 0x10220000.
- resetn asserted while imem_we=1 -> all outputs 0 immediately; later start reloads cleanly from base_addr.

Source files
------------

// File: rtl/mips_isa_pkg.sv
// MIPS ISA definitions shared by the instruction encoder: mnemonic codes,
// opcode/funct values, encoder FSM states and field-packing helpers.
package mips_isa_pkg;

    typedef enum logic [4:0] {
        M_ADD  = 5'd0,
        M_SUB  = 5'd1,
        M_AND  = 5'd2,
        M_OR   = 5'd3,
        M_XOR  = 5'd4,
        M_SLL  = 5'd5,
        M_SRL  = 5'd6,
        M_SRA  = 5'd7,
        M_JR   = 5'd8,
        M_ADDI = 5'd9,
        M_ANDI = 5'd10,
        M_ORI  = 5'd11,
        M_XORI = 5'd12,
        M_LW   = 5'd13,
        M_SW   = 5'd14,
        M_BEQ  = 5'd15,
        M_BNE  = 5'd16,
        M_LUI  = 5'd17,
        M_J    = 5'd18,
        M_JAL  = 5'd19
    } mnem_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL = 6'h00;
    localparam logic [5:0] F_SRL = 6'h02;
    localparam logic [5:0] F_SRA = 6'h03;
    localparam logic [5:0] F_JR  = 6'h08;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_XOR = 6'h26;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } enc_state_e;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] shamt,
                                          input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, shamt, funct};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/mips_enc_word.sv
// Combinational packer: mnemonic plus operand fields -> 32-bit MIPS word.
// With MIPS_ENC_BRREL_EN defined, beq/bne take an absolute word target.
module mips_enc_word
    import mips_isa_pkg::*;
(
    input  logic [4:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [25:0] target,
`ifdef MIPS_ENC_BRREL_EN
    input  logic [15:0] wordIdx,
`endif
    output logic [31:0] word,
    output logic        illegal
);

    logic [15:0] brImm;

`ifdef MIPS_ENC_BRREL_EN
    // Offset is relative to the word after the branch (PC+4).
    assign brImm = imm - (wordIdx + 16'd1);
`else
    assign brImm = imm;
`endif

    always_comb begin
        word    = 32'h0;
        illegal = 1'b0;
        case (mnem)
            M_ADD:  word = rtype(rs, rt, rd, 5'd0, F_ADD);
            M_SUB:  word = rtype(rs, rt, rd, 5'd0, F_SUB);
            M_AND:  word = rtype(rs, rt, rd, 5'd0, F_AND);
            M_OR:   word = rtype(rs, rt, rd, 5'd0, F_OR);
            M_XOR:  word = rtype(rs, rt, rd, 5'd0, F_XOR);
            M_SLL:  word = rtype(5'd0, rt, rd, shamt, F_SLL);
            M_SRL:  word = rtype(5'd0, rt, rd, shamt, F_SRL);
            M_SRA:  word = rtype(5'd0, rt, rd, shamt, F_SRA);
            M_JR:   word = rtype(rs, 5'd0, 5'd0, 5'd0, F_JR);
            M_ADDI: word = itype(OP_ADDI, rs, rt, imm);
            M_ANDI: word = itype(OP_ANDI, rs, rt, imm);
            M_ORI:  word = itype(OP_ORI, rs, rt, imm);
            M_XORI: word = itype(OP_XORI, rs, rt, imm);
            M_LW:   word = itype(OP_LW, rs, rt, imm);
            M_SW:   word = itype(OP_SW, rs, rt, imm);
            M_BEQ:  word = itype(OP_BEQ, rs, rt, brImm);
            M_BNE:  word = itype(OP_BNE, rs, rt, brImm);
            M_LUI:  word = itype(OP_LUI, 5'd0, rt, imm);
            M_J:    word = {OP_J, target};
            M_JAL:  word = {OP_JAL, target};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_inst_encoder.sv
// Streaming MIPS program loader: encodes handshaked instructions and writes them
// sequentially to instruction memory. Optional feature macro: MIPS_ENC_BRREL_EN.
module mips_inst_encoder
    import mips_isa_pkg::*;
#(
    parameter int WCW      = 16,
    parameter int ADDR_INC = 4
) (
    input  logic           clock,
    input  logic           resetn,
    input  logic           start,
    input  logic [31:0]    base_addr,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [4:0]     in_mnem,
    input  logic [4:0]     in_rs,
    input  logic [4:0]     in_rt,
    input  logic [4:0]     in_rd,
    input  logic [4:0]     in_shamt,
    input  logic [15:0]    in_imm,
    input  logic [25:0]    in_target,
    input  logic           in_last,
    output logic           imem_we,
    output logic [31:0]    imem_addr,
    output logic [31:0]    imem_wdata,
    input  logic           imem_ready,
    output logic           done,
    output logic           err_illegal,
    output logic [WCW-1:0] word_count
);

    enc_state_e     state_q, state_d;
    logic           we_q, we_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [31:0]    encPtr_q, encPtr_d;
    logic [WCW-1:0] wordCount_q, wordCount_d;
    logic           err_q, err_d;

    logic [31:0]    encWord;
    logic           encIllegal;
    logic           accept;
    logic           writeDone;

    mips_enc_word u_enc_word (
        .mnem    (in_mnem),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .shamt   (in_shamt),
        .imm     (in_imm),
        .target  (in_target),
`ifdef MIPS_ENC_BRREL_EN
        .wordIdx (encPtr_q[17:2]),
`endif
        .word    (encWord),
        .illegal (encIllegal)
    );

    assign in_ready  = (state_q == ST_RUN) && (!we_q || imem_ready);
    assign accept    = in_valid && in_ready;
    assign writeDone = we_q && imem_ready;

    // The buffer address always points at the next slot to write, so a word
    // accepted alongside a completing write picks up the incremented address.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        encPtr_d    = encPtr_q;
        wordCount_d = wordCount_q;
        err_d       = err_q;

        if (writeDone) begin
            we_d        = 1'b0;
            addr_d      = addr_q + 32'(ADDR_INC);
            wordCount_d = wordCount_q + WCW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    encPtr_d    = base_addr;
                    addr_d      = base_addr;
                    wordCount_d = '0;
                    err_d       = 1'b0;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (encIllegal) begin
                        err_d = 1'b1;
                    end else begin
                        we_d     = 1'b1;
                        wdata_d  = encWord;
                        encPtr_d = encPtr_q + 32'(ADDR_INC);
                    end
                    if (in_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!we_q || imem_ready) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            encPtr_q    <= 32'h0;
            wordCount_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            encPtr_q    <= encPtr_d;
            wordCount_q <= wordCount_d;
            err_q       <= err_d;
        end
    end

    assign imem_we     = we_q;
    assign imem_addr   = addr_q;
    assign imem_wdata  = wdata_q;
    assign done        = (state_q == ST_DONE);
    assign err_illegal = err_q;
    assign word_count  = wordCount_q;

endmodule
